axis_rr_fifo_arbiter: RTL
=========================

Name: axis_rr_fifo_arbiter

Overview:
Round-robin arbiter that shares the write port of one axis_sync_fifo among NUM_SRC AXI-Stream producers (e.g. per-channel waveform loaders) in the PL clock domain. It grants one source at a time for a bounded burst, muxes that source's data onto the FIFO input, and steers FIFO backpressure back only to the granted source. Its output connects directly to the s_axis_* port of axis_sync_fifo.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
bus_width, 256, AXIS data width in bits; matches the FIFO bus_width
MAX_BURST, 16, maximum beats transferred per grant (1..256)

Ports:
axis_clk  in  1  PL clock; all logic is on its rising edge
rst  in  1  asynchronous, active-low reset
src_enable  in  NUM_SRC  per-source arbitration enable mask
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tready  out  NUM_SRC  per-source ready; only the granted bit can be 1
s_axis_tdata  in  NUM_SRC*bus_width  packed source data; source i occupies [i*bus_width +: bus_width]
m_axis_tdata  out  bus_width  data to the FIFO write port
m_axis_tvalid  out  1  valid to the FIFO write port
m_axis_tready  in  1  FIFO s_axis_tready
grant_active  out  1  high while in GRANT
grant_id  out  $clog2(NUM_SRC)  index of the granted or last-granted source

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, grant_active=0, all s_axis_tready=0, m_axis_tvalid=0. m_axis_tdata is don't-care but is driven as 0.
- Reset mid-burst: the in-flight beat is dropped (no handshake). The FIFO is reset by the same rst.
- FSM states: IDLE and GRANT.
- IDLE:
  - m_axis_tvalid=0 and all tready=0.
  - Candidate set = s_axis_tvalid & src_enable.
  - Search the candidate set starting at rr_ptr and wrapping modulo NUM_SRC. The first hit i is registered: next cycle state=GRANT, grant_id=i, burst_cnt=0.
  - Arbitration latency is 1 cycle from valid to grant. No candidates: remain in IDLE.
- GRANT, with g=grant_id:
  - Combinational path: m_axis_tvalid=s_axis_tvalid[g], m_axis_tdata=source g data, s_axis_tready[g]=m_axis_tready. All other tready bits are 0.
  - A beat transfers when s_axis_tvalid[g] && m_axis_tready. burst_cnt increments on each beat; its width is $clog2(MAX_BURST+1).
- Release conditions (any one, evaluated each cycle in GRANT):
  - (a) A beat occurs and burst_cnt==MAX_BURST-1.
  - (b) s_axis_tvalid[g]==0.
  - (c) src_enable[g]==0 and s_axis_tvalid[g]==0.
  - src_enable deassertion while s_axis_tvalid[g]=1 is deferred until that beat completes, then the arbiter releases. This keeps the AXIS rule that valid is never withdrawn by the arbiter.
- On release: next state=IDLE, rr_ptr=(g+1) mod NUM_SRC, and grant_id holds g.
  - IDLE always lasts at least 1 cycle between grants.
  - Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles under continuous demand.
- FIFO full (m_axis_tready=0): the grant holds and burst_cnt is frozen. Stalls never count toward MAX_BURST and never release the grant.
- Fairness: a source that has valid and is enabled waits at most NUM_SRC-1 other grants.
- MAX_BURST=1: release after every beat; pure per-beat round robin.
- Data ordering: beats from one source reach the FIFO in source order. Bursts from different sources are never interleaved within a grant.
- No combinational path from m_axis_tready to any output other than s_axis_tready.

Decomposition:
- Package rfsoc_config gains:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
  - constants ARB_NUM_SRC=4 and ARB_MAX_BURST=16, used by the instantiating top level.
- One combinational sub-module, rr_priority_select, parameterised by NUM_SRC:
  - inputs: request vector and rr_ptr.
  - outputs: found flag and index.
  - Implemented by doubling the request vector and masking.
- The FSM, counter and mux stay in axis_rr_fifo_arbiter. The top level instantiates it in front of axis_sync_fifo.

Test Plan:
- Reset priority: reset, then src 0..3 all valid continuously, FIFO always ready, MAX_BURST=16 → grants 0,1,2,3,0 in order. Each burst is exactly 16 beats, with exactly 1 IDLE cycle between bursts.
- Release on idle and rotation: only src2 valid for 5 beats, then low → grant releases after 5 beats, and rr_ptr=3. A later simultaneous request from src1 and src3 is granted to src3 first.
- Backpressure: m_axis_tready toggles 1,0,0,1 repeatedly → burst still ends after 16 transferred beats. The FIFO receives the source's data values 0..15 in order, with no duplicates or drops.
- Enable mask: src_enable=4'b1011 with all sources valid → src2 is never granted. Clearing src_enable[1] mid-burst while its tvalid=1 → the current beat completes, then the grant releases. src1 never has tvalid withdrawn by the arbiter.
- MAX_BURST=1 with two sources continuously valid → the beat sequence alternates src0, src1, with 1 IDLE cycle between beats.
- Async reset mid-burst (rst=0 for 1 cycle during beat 7) → all outputs return to reset values within that cycle. The first grant after reset goes to src0.

Source files
------------

// File: rtl/rfsoc_config_pkg.sv
// Shared PL configuration: arbiter state encoding, default arbiter sizing
// used by the instantiating top level, and a small wrap-around helper.
package rfsoc_config;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Default arbiter sizing for the waveform-loader front end.
  localparam int ARB_NUM_SRC   = 4;
  localparam int ARB_MAX_BURST = 16;

  // (value + 1) mod modulus, for round-robin pointer advance.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority picker: finds the first set request at or after ptr,
// wrapping modulo NUM_SRC. The request vector is doubled with the low copy
// masked below ptr, so the lowest set bit of the doubled vector is the winner.
module rr_priority_select
  import rfsoc_config::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [NUM_SRC-1:0]   mask;
  logic [2*NUM_SRC-1:0] dbl;
  int                   pos;

  // Keep only requests at or above the pointer in the low copy.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mask
    assign mask[gi] = (IW'(gi) >= ptr);
  end

  assign dbl = {req, req & mask};

  // Lowest set bit of the doubled vector; folding back gives the source index.
  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int j = 2 * NUM_SRC - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        found = 1'b1;
        pos   = j;
      end
    end
    idx = (pos >= NUM_SRC) ? IW'(pos - NUM_SRC) : IW'(pos);
  end

endmodule

// File: rtl/axis_rr_fifo_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream FIFO write port among NUM_SRC
// producers. One source is granted at a time for up to MAX_BURST beats; its
// data is muxed to the FIFO and FIFO backpressure is steered only to it.
module axis_rr_fifo_arbiter
  import rfsoc_config::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int bus_width = 256,
  parameter int MAX_BURST = 16,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                           axis_clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_enable,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*bus_width-1:0]   s_axis_tdata,
  output logic [bus_width-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           grant_active,
  output logic [IW-1:0]                  grant_id
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        burst_cnt;

  logic [NUM_SRC-1:0]   candidates;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;

  logic                 in_grant;
  logic                 g_valid;
  logic                 g_enable;
  logic                 beat;
  logic                 last_beat;
  logic                 release_now;
  logic [IW-1:0]        next_ptr;

  logic [bus_width-1:0] src_data [NUM_SRC];

  assign candidates = s_axis_tvalid & src_enable;

  rr_priority_select #(
    .NUM_SRC (NUM_SRC)
  ) u_select (
    .req   (candidates),
    .ptr   (rr_ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Unpack the per-source data words for the output mux.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_data[gi] = s_axis_tdata[gi*bus_width +: bus_width];
  end

  // Only the granted source sees FIFO ready; everything else is held off.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign s_axis_tready[gi] = in_grant && (grant_id == IW'(gi)) && m_axis_tready;
  end

  // Grant-phase decode: beat detection and release decision.
  always_comb begin
    in_grant  = (state == ARB_GRANT);
    g_valid   = s_axis_tvalid[grant_id];
    g_enable  = src_enable[grant_id];
    beat      = in_grant && g_valid && m_axis_tready;
    last_beat = (burst_cnt == CW'(MAX_BURST - 1));
    // A disabled source that still holds valid is allowed to finish its
    // current beat; the grant is dropped only once that beat has moved.
    release_now = in_grant && (!g_valid || (beat && (last_beat || !g_enable)));
    next_ptr    = IW'(wrap_inc(int'(grant_id), NUM_SRC));
  end

  // Output path to the FIFO: pass-through of the granted source, zero otherwise.
  always_comb begin
    m_axis_tvalid = in_grant && g_valid;
    m_axis_tdata  = in_grant ? src_data[grant_id] : '0;
  end

  // Arbitration FSM with burst counter and round-robin pointer.
  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      burst_cnt    <= '0;
      grant_active <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_found) begin
            state        <= ARB_GRANT;
            grant_id     <= sel_idx;
            burst_cnt    <= '0;
            grant_active <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state        <= ARB_IDLE;
            rr_ptr       <= next_ptr;
            burst_cnt    <= '0;
            grant_active <= 1'b0;
          end else if (beat) begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: begin
          state        <= ARB_IDLE;
          grant_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
